// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB/BRANCH plus TRAP and ERR,
// with a memory wait timeout. Define ILLEGAL_TRAP_EN to trap illegal instructions.
module mc_control_fsm #(
    parameter int WAIT_LIMIT = 15,
    parameter int WAIT_W     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] function_code,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] ALUop,
    output logic [1:0] pc_src,
    output logic [2:0] state,
    output logic       bus_error,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_BRANCH = 3'd5,
        S_TRAP   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_SUBI = 6'b000011;
    localparam logic [5:0] OP_ANDI = 6'b000100;
    localparam logic [5:0] OP_ORI  = 6'b000101;
    localparam logic [5:0] OP_BEQ  = 6'b000110;
    localparam logic [5:0] OP_SLTI = 6'b000111;
    localparam logic [5:0] OP_BNE  = 6'b001001;
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [WAIT_W-1:0] LIMIT      = WAIT_W'(WAIT_LIMIT);
    localparam bit                TIMEOUT_EN = (WAIT_LIMIT != 0);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic is_r, is_jr, is_imm, is_load, is_store, is_beq, is_bne, is_j;
    logic r_fn_legal, bad_instr, limit_hit;
    logic [2:0] imm_aluop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        is_r       = (opcode == OP_R);
        is_jr      = is_r && (function_code == FN_JR);
        is_load    = (opcode == OP_LB) || (opcode == OP_LW);
        is_store   = (opcode == OP_SB) || (opcode == OP_SW);
        is_beq     = (opcode == OP_BEQ);
        is_bne     = (opcode == OP_BNE);
        is_j       = (opcode == OP_J);
        is_imm     = 1'b1;
        imm_aluop  = 3'b101;
        case (opcode)
            OP_ADDI: imm_aluop = 3'b101;
            OP_SUBI: imm_aluop = 3'b110;
            OP_ANDI: imm_aluop = 3'b000;
            OP_ORI:  imm_aluop = 3'b001;
            OP_SLTI: imm_aluop = 3'b100;
            default: is_imm    = 1'b0;
        endcase
        r_fn_legal = (function_code == 6'b000010) || (function_code == 6'b000011) ||
                     (function_code == 6'b000100) || (function_code == 6'b000101) ||
                     (function_code == 6'b000111) || (function_code == FN_JR);
        bad_instr  = !(is_r || is_imm || is_load || is_store || is_beq || is_bne || is_j) ||
                     (is_r && !r_fn_legal);
        limit_hit  = TIMEOUT_EN && (wait_q == LIMIT);
    end

    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        ALUop      = 3'b000;
        pc_src     = 2'b00;
        bus_error  = 1'b0;
        illegal    = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ALUop     = 3'b101;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end else if (limit_hit) begin
                    state_d = S_ERR;
                end
            end
            S_DECODE: begin
                ALUop     = 3'b101;
                alu_src_b = 2'b11;
                if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = 2'b10;
                    state_d  = S_FETCH;
                end else if (is_beq || is_bne) begin
                    state_d = S_BRANCH;
                end else if (bad_instr) begin
`ifdef ILLEGAL_TRAP_EN
                    state_d = S_TRAP;
`else
                    state_d = S_FETCH;
`endif
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_r) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b00;
                    ALUop     = 3'b111;
                    if (is_jr) begin
                        pc_write = 1'b1;
                        pc_src   = 2'b11;
                        state_d  = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (is_imm) begin
                    alu_src_b = 2'b10;
                    ALUop     = imm_aluop;
                    state_d   = S_WB;
                end else begin
                    alu_src_b = 2'b10;
                    ALUop     = 3'b101;
                    state_d   = S_MEM;
                end
            end
            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                if (mem_ready) begin
                    state_d = is_load ? S_WB : S_FETCH;
                end else if (limit_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                reg_dst    = is_r;
                mem_to_reg = is_load;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                ALUop     = 3'b110;
                pc_src    = 2'b01;
                pc_write  = is_beq ? zero : ~zero;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
`ifdef ILLEGAL_TRAP_EN
                illegal = 1'b1;
`endif
            end
            S_ERR: begin
                bus_error = 1'b1;
            end
        endcase

        // The counter only measures consecutive stalls within one memory-facing state.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready && wait_q != LIMIT) begin
            wait_d = wait_q + 1'b1;
        end else begin
            wait_d = wait_q;
        end

        state = state_q;
        // Reset kills every strobe combinationally so an aborted access never writes.
        if (reset) begin
            state      = S_FETCH;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            i_or_d     = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            ALUop      = 3'b000;
            pc_src     = 2'b00;
            bus_error  = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule
